// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: FSM state encoding, default operand widths and ALU flag bit positions
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam int A_W_DEF = 4;
  localparam int B_W_DEF = 2;
  localparam int SEL_W_DEF = 2;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/alu_arb_picker.sv
// alu_arb_picker: one-hot grant between two requesters; a tie goes to req0 when last_i is 1, else req1
module alu_arb_picker (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);
  assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_i);
  assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise req0 always wins ties.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [A_W-1:0]   req0_a,
  input  logic [B_W-1:0]   req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [A_W-1:0]   req1_a,
  input  logic [B_W-1:0]   req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [A_W-1:0]   alu_a,
  output logic [B_W-1:0]   alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [A_W-1:0]   alu_y,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [A_W-1:0]   rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             busy
);
  state_e state_q, state_d;
  logic [A_W-1:0] a_q, y_q;
  logic [B_W-1:0] b_q;
  logic [SEL_W-1:0] sel_q;
  logic [3:0] flags_q;
  logic id_q, last, xfer;
  logic [1:0] grant;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else if (xfer) last_q <= grant[1];
  assign last = last_q;
`else
  assign last = 1'b1;
`endif

  alu_arb_picker u_picker (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last),
    .grant_o (grant)
  );

  assign req0_ready = (state_q == IDLE) & grant[0];
  assign req1_ready = (state_q == IDLE) & grant[1];
  assign xfer = req0_ready | req1_ready;

  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (xfer ? EXEC : IDLE) :
              (state_q == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      id_q    <= 1'b0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        a_q   <= req1_ready ? req1_a : req0_a;
        b_q   <= req1_ready ? req1_b : req0_b;
        sel_q <= req1_ready ? req1_sel : req0_sel;
        id_q  <= req1_ready;
      end
      if (state_q == EXEC) begin
        y_q     <= alu_y;
        flags_q <= alu_flags;
      end
    end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;
  assign rsp_flags = flags_q;
  assign busy      = state_q != IDLE;
endmodule
